// File: rtl/mem_port_arbiter.sv
// Purpose : arbitrates IF fetches and MEM loads/stores onto one single-ported,
//           variable-latency memory. Data has priority, and a streak counter
//           guarantees that fetch is served.
// Latency : request to ready is 2 + backend ack wait cycles. Arbitration is
//           registered. A response cycle sits between grants.
// Backpr. : the requester holds req until its ready pulse. if_stall and
//           d_stall are combinational. The backend holds the pipeline through
//           m_req until m_ack.
// Ports   : clk, reset (async, active-high)
//           IF  side : if_req, if_addr, if_cancel -> if_rdata, if_ready, if_stall
//           MEM side : d_req, d_we, d_addr, d_wdata -> d_rdata, d_ready, d_stall
//           backend  : m_req, m_we, m_addr, m_wdata <- m_ack, m_rdata
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_cancel,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              d_stall,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ack,
  input  logic [DATA_W-1:0] m_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    GRANT_I,
    GRANT_D,
    DRAIN,
    RESP_I,
    RESP_D
  } state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

  state_t     state;
  logic [3:0] streak;
  logic       d_wins;

  // Data wins the port unless fetch is waiting and has already been
  // passed over MAX_D_STREAK times in a row.
  assign d_wins   = d_req && !(if_req && (streak == STREAK_MAX));

  assign if_stall = if_req && !if_ready;
  assign d_stall  = d_req && !d_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      streak   <= '0;
      m_req    <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      if_rdata <= '0;
      d_rdata  <= '0;
    end else begin
      // Ready outputs pulse for one cycle only. This is the RESP_x cycle.
      if_ready <= 1'b0;
      d_ready  <= 1'b0;

      case (state)
        IDLE: begin
          if (d_wins) begin
            m_req   <= 1'b1;
            m_we    <= d_we;
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
            state   <= GRANT_D;
            // Count data grants only while fetch is waiting. Saturate at the limit.
            if (if_req)
              streak <= (streak == STREAK_MAX) ? streak : streak + 4'd1;
            else
              streak <= '0;
          end else if (if_req && !if_cancel) begin
            m_req  <= 1'b1;
            m_we   <= 1'b0;
            m_addr <= if_addr;
            state  <= GRANT_I;
            streak <= '0;
          end
        end

        GRANT_D: begin
          if (m_ack) begin
            if (!m_we)
              d_rdata <= m_rdata;
            m_req   <= 1'b0;
            m_we    <= 1'b0;
            d_ready <= 1'b1;
            state   <= RESP_D;
          end
        end

        GRANT_I: begin
          if (if_cancel) begin
            // A flushed fetch cannot be aborted at the backend. If the ack has
            // not arrived yet, wait for it in DRAIN and discard the data.
            if (m_ack) begin
              m_req <= 1'b0;
              state <= IDLE;
            end else begin
              state <= DRAIN;
            end
          end else if (m_ack) begin
            if_rdata <= m_rdata;
            if_ready <= 1'b1;
            m_req    <= 1'b0;
            state    <= RESP_I;
          end
        end

        DRAIN: begin
          if (m_ack) begin
            m_req <= 1'b0;
            state <= IDLE;
          end
        end

        // One dead cycle. The requester still shows req here because it
        // drops req only after seeing ready, so no grant is made.
        RESP_I,
        RESP_D: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule
